// File: rtl/bus_bridge_mc.sv
// Handshaked CPU-to-device bridge: windowed slot decode, wait states via sel/ack,
// timeout and decode/alignment errors. One transaction in flight at a time.

module bus_bridge_mc_slot #(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] last,
  output logic              hit
);
  assign hit = (addr >= base) && (addr <= last);
endmodule

module bus_bridge_mc #(
  parameter int                      N_DEV    = 4,
  parameter int                      ADDR_W   = 32,
  parameter int                      DATA_W   = 32,
  parameter logic [N_DEV*ADDR_W-1:0] DEV_BASE = {32'h7F20, 32'h7F10, 32'h7F00, 32'h0000},
  parameter logic [N_DEV*ADDR_W-1:0] DEV_LAST = {32'h7F23, 32'h7F1B, 32'h7F0B, 32'h2FFF},
  parameter int                      TIMEOUT  = 15
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [ADDR_W-1:0]       cpu_addr,
  input  logic [DATA_W/8-1:0]     cpu_byteen,
  input  logic [DATA_W-1:0]       cpu_wdata,
  output logic                    cpu_ready,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_err,
  output logic [ADDR_W-1:0]       err_addr,
  output logic [N_DEV-1:0]        dev_sel,
  output logic                    dev_we,
  output logic [ADDR_W-1:0]       dev_addr,
  output logic [DATA_W-1:0]       dev_wdata,
  output logic [DATA_W/8-1:0]     dev_byteen,
  input  logic [N_DEV*DATA_W-1:0] dev_rdata,
  input  logic [N_DEV-1:0]        dev_ack
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [N_DEV-1:0]  hit, hit_1h;
  logic              misaligned, no_match, ack_sel;
  logic [DATA_W-1:0] sel_rdata;

  for (genvar i = 0; i < N_DEV; i++) begin : g_slot
    bus_bridge_mc_slot #(.ADDR_W(ADDR_W)) u_slot (
      .addr (cpu_addr),
      .base (DEV_BASE[i*ADDR_W +: ADDR_W]),
      .last (DEV_LAST[i*ADDR_W +: ADDR_W]),
      .hit  (hit[i])
    );
  end

  // Walk high-to-low so the lowest matching slot is the one left standing.
  always_comb begin
    hit_1h = '0;
    for (int i = N_DEV - 1; i >= 0; i--)
      if (hit[i]) begin
        hit_1h    = '0;
        hit_1h[i] = 1'b1;
      end
  end

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_DEV; i++)
      if (dev_sel[i]) sel_rdata = sel_rdata | dev_rdata[i*DATA_W +: DATA_W];
  end

  assign misaligned = |cpu_addr[1:0];
  assign no_match   = ~|hit;
  assign ack_sel    = |(dev_ack & dev_sel);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      cpu_ready  <= 1'b0;
      cpu_rdata  <= '0;
      cpu_err    <= 1'b0;
      err_addr   <= '0;
      dev_sel    <= '0;
      dev_we     <= 1'b0;
      dev_addr   <= '0;
      dev_wdata  <= '0;
      dev_byteen <= '0;
    end else begin
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= '0;
      case (state)
        IDLE: if (cpu_req) begin
          if (no_match || misaligned) begin
            state     <= RESP;
            cpu_ready <= 1'b1;
            cpu_err   <= 1'b1;
            err_addr  <= cpu_addr;
          end else if (cpu_we && cpu_byteen == '0) begin
            state     <= RESP;
            cpu_ready <= 1'b1;
          end else begin
            state      <= ACCESS;
            dev_sel    <= hit_1h;
            dev_we     <= cpu_we;
            dev_addr   <= cpu_addr;
            dev_wdata  <= cpu_wdata;
            dev_byteen <= cpu_we ? cpu_byteen : '0;
            wait_cnt   <= '0;
          end
        end
        ACCESS: begin
          // Ack is checked first so it beats a timeout landing in the same cycle.
          if (ack_sel) begin
            state     <= RESP;
            cpu_ready <= 1'b1;
            cpu_rdata <= dev_we ? '0 : sel_rdata;
            dev_sel   <= '0;
          end else if (wait_cnt == CNT_LAST) begin
            state     <= RESP;
            cpu_ready <= 1'b1;
            cpu_err   <= 1'b1;
            err_addr  <= dev_addr;
            dev_sel   <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_bridge_mc.sv
// Bench for bus_bridge_mc: directed vector table, reset/back-to-back sequences and
// randomized transactions checked against a window-decode reference model.

module tb_bus_bridge_mc;
  localparam int TO = 15;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    int          ack;   // wait cycles before ack; >= TO means never
    logic [31:0] rdv;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  sel;
    logic [3:0]  dbe;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0]  cpu_addr = '0, cpu_wdata = '0;
  logic [3:0]   cpu_byteen = '0;
  logic         cpu_ready, cpu_err, dev_we;
  logic [31:0]  cpu_rdata, err_addr, dev_addr, dev_wdata;
  logic [3:0]   dev_sel, dev_byteen;
  logic [127:0] dev_rdata = '0;
  logic [3:0]   dev_ack = '0;

  int n_cmp = 0, n_bad = 0;
  logic [31:0] exp_err_addr = '0;
  logic [31:0] base_a [4] = '{32'h0000, 32'h7F00, 32'h7F10, 32'h7F20};
  logic [31:0] last_a [4] = '{32'h2FFF, 32'h7F0B, 32'h7F1B, 32'h7F23};
  vec_t tbl [13];

  bus_bridge_mc #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_byteen(cpu_byteen), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
    .err_addr(err_addr), .dev_sel(dev_sel), .dev_we(dev_we), .dev_addr(dev_addr),
    .dev_wdata(dev_wdata), .dev_byteen(dev_byteen), .dev_rdata(dev_rdata),
    .dev_ack(dev_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int ref_slot(input logic [31:0] a);
    int s;
    s = -1;
    for (int i = 3; i >= 0; i--)
      if (a >= base_a[i] && a <= last_a[i]) s = i;
    return s;
  endfunction

  function automatic vec_t ref_model(input logic we, input logic [31:0] a, input logic [3:0] be,
                                     input logic [31:0] wd, input int d, input logic [31:0] rdv);
    vec_t v;
    int s;
    v = '{we, a, be, wd, d, rdv, 1, 1'b0, 32'h0, 4'h0, 4'h0};
    s = ref_slot(a);
    if (s < 0 || a[1:0] != 2'b00) v.err = 1'b1;
    else if (!(we && be == 4'h0)) begin
      v.sel = 4'(1) << s;
      v.dbe = we ? be : 4'h0;
      if (d < TO) begin
        v.lat   = 2 + d;
        v.rdata = we ? 32'h0 : rdv;
      end else begin
        v.lat = TO + 1;
        v.err = 1'b1;
      end
    end
    return v;
  endfunction

  task automatic run(input vec_t v, input logic [3:0] spur, input bit hold);
    int lat, sel_cyc;
    logic [3:0] sp;
    sp = spur & ~v.sel;
    for (int i = 0; i < 4; i++) dev_rdata[i*32 +: 32] = v.sel[i] ? v.rdv : ~v.rdv;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_byteen = v.be; cpu_wdata = v.wd;
    dev_ack = sp;
    lat = 0; sel_cyc = 0;
    for (int c = 1; c <= 40 && lat == 0; c++) begin
      @(negedge clk);
      if (!hold) cpu_req = 1'b0;
      dev_ack = sp;
      if (cpu_ready) begin
        lat = c;
        if (v.err) exp_err_addr = v.addr;
        chk("cpu_err", cpu_err, v.err);
        chk("cpu_rdata", cpu_rdata, v.rdata);
        chk("err_addr", err_addr, exp_err_addr);
        chk("sel_in_resp", dev_sel, 0);
      end else if (dev_sel != 4'h0) begin
        sel_cyc++;
        chk("dev_sel", dev_sel, v.sel);
        if (sel_cyc == 1) begin
          chk("dev_we", dev_we, v.we);
          chk("dev_addr", dev_addr, v.addr);
          chk("dev_wdata", dev_wdata, v.wd);
          chk("dev_byteen", dev_byteen, v.dbe);
        end
        if (c - 1 == v.ack) dev_ack = dev_ack | v.sel;
      end
    end
    chk("latency", lat, v.lat);
    chk("sel_cycles", sel_cyc, (v.sel == 4'h0) ? 0 : v.lat - 1);
    dev_ack = '0;
  endtask

  task automatic idle_chk(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_outputs", {cpu_ready, cpu_err, dev_sel, cpu_rdata}, 0);
    end
  endtask

  task automatic rand_txn();
    logic we;
    logic [31:0] a;
    logic [3:0] be;
    int s, d;
    vec_t v;
    s  = $urandom_range(0, 3);
    we = 1'($urandom);
    be = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
    d  = $urandom_range(0, 16);
    case ($urandom_range(0, 3))
      0:       a = base_a[s] + 32'($urandom_range(0, (last_a[s] - base_a[s]) / 4)) * 4;
      1:       a = 32'h3000 + 32'($urandom_range(0, 32'h13BF)) * 4;
      2:       a = base_a[s] + 32'($urandom_range(1, 3));
      default: a = $urandom;
    endcase
    v = ref_model(we, a, be, $urandom, d, $urandom);
    run(v, 4'($urandom), 1'b0);
    idle_chk(1);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 32'h0000_0010, 4'h0, 32'h0,        0, 32'hDEADBEEF, 2,  1'b0, 32'hDEADBEEF, 4'b0001, 4'h0};
    tbl[1]  = '{1'b1, 32'h0000_7F04, 4'h3, 32'h1234,     3, 32'h5555AAAA, 5,  1'b0, 32'h0,        4'b0010, 4'h3};
    tbl[2]  = '{1'b0, 32'h0000_5000, 4'h0, 32'h0,       -1, 32'h0,        1,  1'b1, 32'h0,        4'b0000, 4'h0};
    tbl[3]  = '{1'b0, 32'h0000_7F02, 4'h0, 32'h0,       -1, 32'h0,        1,  1'b1, 32'h0,        4'b0000, 4'h0};
    tbl[4]  = '{1'b0, 32'h0000_7F20, 4'h0, 32'h0,       -1, 32'h11112222, 16, 1'b1, 32'h0,        4'b1000, 4'h0};
    tbl[5]  = '{1'b0, 32'h0000_7F20, 4'h0, 32'h0,       14, 32'hA5A50F0F, 16, 1'b0, 32'hA5A50F0F, 4'b1000, 4'h0};
    tbl[6]  = '{1'b1, 32'h0000_7F10, 4'h0, 32'h99,       0, 32'h0,        1,  1'b0, 32'h0,        4'b0000, 4'h0};
    tbl[7]  = '{1'b0, 32'h0000_7F1C, 4'h0, 32'h0,        0, 32'h0,        1,  1'b1, 32'h0,        4'b0000, 4'h0};
    tbl[8]  = '{1'b0, 32'h0000_2FFC, 4'h0, 32'h0,        1, 32'h0BADF00D, 3,  1'b0, 32'h0BADF00D, 4'b0001, 4'h0};
    tbl[9]  = '{1'b0, 32'h0000_7F08, 4'hF, 32'h0,        0, 32'hCAFE0001, 2,  1'b0, 32'hCAFE0001, 4'b0010, 4'h0};
    tbl[10] = '{1'b1, 32'h0000_7F18, 4'hF, 32'h87654321, 2, 32'hFFFF0000, 4,  1'b0, 32'h0,        4'b0100, 4'hF};
    tbl[11] = '{1'b1, 32'h0000_3000, 4'hF, 32'h1,        0, 32'h0,        1,  1'b1, 32'h0,        4'b0000, 4'h0};
    tbl[12] = '{1'b1, 32'h0000_7F0C, 4'h1, 32'h2,        0, 32'h0,        1,  1'b1, 32'h0,        4'b0000, 4'h0};

    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    chk("reset_state", {cpu_ready, cpu_err, dev_sel, dev_byteen, cpu_rdata, err_addr}, 0);
    idle_chk(2);

    for (int i = 0; i < 13; i++) begin
      run(tbl[i], 4'h0, 1'b0);
      idle_chk(1);
    end

    // Reset in the middle of a slot1 write: everything drops without a ready pulse.
    dev_rdata = '0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h7F04; cpu_byteen = 4'h3; cpu_wdata = 32'h1234;
    @(negedge clk);
    cpu_req = 1'b0;
    @(negedge clk);
    chk("sel_before_reset", dev_sel, 4'b0010);
    #2 reset_n = 1'b0;
    #1 chk("reset_async", {cpu_ready, dev_sel, dev_byteen}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ready_in_reset", cpu_ready, 1'b0);
    end
    reset_n = 1'b1;
    exp_err_addr = '0;
    chk("err_addr_cleared", err_addr, 0);
    run(tbl[0], 4'h0, 1'b0);
    idle_chk(1);

    // Spurious slot2 acks throughout, request held high through RESP.
    run(ref_model(1'b0, 32'h40, 4'h0, 32'h0, 2, 32'h13572468), 4'b0100, 1'b1);
    run(ref_model(1'b0, 32'h7F00, 4'h0, 32'h0, 0, 32'h24681357), 4'b0100, 1'b0);
    idle_chk(3);

    for (int n = 0; n < 60; n++) rand_txn();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
